// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial Mealy sequence detector among NUM_REQ requesters.
// Optional saturating hit counter enabled by defining SCHED_HIT_COUNT_EN.
module seq_detect_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WORD_W  = 4,
   parameter int ID_W    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*WORD_W-1:0]   word_data,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        det_rst_n,
   output logic                        det_in,
   input  logic                        det_dec,
   output logic                        res_valid,
   output logic [ID_W-1:0]             res_id,
   output logic                        res_hit,
   input  logic                        res_ready,
   output logic                        busy,
   output logic [15:0]                 hit_count
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

   logic [1:0]        state_q,   state_d;
   logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;
   logic [WORD_W-1:0] shift_q,   shift_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [ID_W-1:0]   res_id_q,  res_id_d;
   logic              res_hit_q, res_hit_d;

   logic              pick_vld;
   logic [ID_W-1:0]   pick_idx;
   logic [ID_W-1:0]   cand;

   // Scan from the highest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int o = NUM_REQ - 1; o >= 0; o--) begin
         cand = ID_W'((int'(rr_ptr_q) + o) % NUM_REQ);
         if (req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (!rst && state_q == ST_IDLE && pick_vld) begin
         grant[pick_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      res_id_d  = res_id_q;
      res_hit_d = res_hit_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               shift_d   = word_data[pick_idx*WORD_W +: WORD_W];
               res_id_d  = pick_idx;
               rr_ptr_d  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Only the Mealy output for the last bit of the word is meaningful.
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
               res_hit_d = det_dec;
               bit_cnt_d = '0;
               state_d   = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         res_id_q  <= '0;
         res_hit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         res_id_q  <= res_id_d;
         res_hit_q <= res_hit_d;
      end
   end

   assign det_rst_n = (state_q == ST_SHIFT);
   assign det_in    = (state_q == ST_SHIFT) ? shift_q[WORD_W-1] : 1'b0;
   assign res_valid = (state_q == ST_RESULT);
   assign res_id    = res_id_q;
   assign res_hit   = res_hit_q;
   assign busy      = (state_q != ST_IDLE);

`ifdef SCHED_HIT_COUNT_EN
   logic [15:0] hit_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count_q <= '0;
      end else if (res_valid && res_ready && res_hit_q && hit_count_q != 16'hFFFF) begin
         hit_count_q <= hit_count_q + 1'b1;
      end
   end

   assign hit_count = hit_count_q;
`else
   assign hit_count = '0;
`endif

endmodule
